seq_bin2bcd: RTL

SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

---
 rtl/seq_bin2bcd.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_bin2bcd.sv
// ============================================================================
// Module   : seq_bin2bcd
// Brief    : Iterative binary-to-BCD converter (shift-and-add-3, 1 bit/cycle).
//            Optional two's-complement input when BIN2BCD_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_bin2bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int         c_BCD_W = 4 * DIGITS;
  localparam logic [4:0] c_LAST  = 5'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_sr;
  logic [c_BCD_W-1:0]   r_acc;
  logic [4:0]           r_cnt;
  logic                 r_ovf_trk;
  logic                 r_busy;
  logic                 r_done;
  logic [c_BCD_W-1:0]   r_bcd;
  logic                 r_ovf;

  logic [c_BCD_W-1:0]   w_acc_adj;
  logic [c_BCD_W-1:0]   w_acc_nxt;
  logic                 w_spill;
  logic [WIDTH-1:0]     w_mag;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign w_acc_adj[4*d +: 4] = (r_acc[4*d +: 4] >= 4'd5) ? (r_acc[4*d +: 4] + 4'd3)
                                                           : r_acc[4*d +: 4];
  end

  // Bit leaving the top digit means the value no longer fits in DIGITS digits.
  assign w_spill   = w_acc_adj[c_BCD_W-1];
  assign w_acc_nxt = {w_acc_adj[c_BCD_W-2:0], r_sr[WIDTH-1]};

`ifdef BIN2BCD_SIGNED_EN
  logic w_sign;
  logic r_sign;
  logic r_neg;
  assign w_sign = bin[WIDTH-1];
  // Negating -2^(WIDTH-1) wraps to itself, which read unsigned is the magnitude.
  assign w_mag  = w_sign ? ((~bin) + WIDTH'(1)) : bin;
  assign neg    = r_neg;
`else
  assign w_mag  = bin;
  assign neg    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_trk <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      r_sign    <= 1'b0;
      r_neg     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SHIFT: begin
          r_acc     <= w_acc_nxt;
          r_sr      <= {r_sr[WIDTH-2:0], 1'b0};
          r_ovf_trk <= r_ovf_trk | w_spill;
          if (r_cnt == c_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bcd   <= w_acc_nxt;
            r_ovf   <= r_ovf_trk | w_spill;
`ifdef BIN2BCD_SIGNED_EN
            r_neg   <= r_sign;
`endif
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: begin
          if (start) begin
            r_state   <= SHIFT;
            r_busy    <= 1'b1;
            r_sr      <= w_mag;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_trk <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            r_sign    <= w_sign;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire
